// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the multi-port register file with busy scoreboard:
//   - state_t       : clear-sweep FSM encoding (ST_IDLE, ST_CLEAR)
//   - ZERO_REG      : index of the hard-wired zero register
//   - DEFAULT_*     : default data width, index width and read-port count
// -----------------------------------------------------------------------------
package regfile_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam int unsigned ZERO_REG           = 0;
  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 5;
  localparam int unsigned DEFAULT_NUM_READ   = 2;

endpackage

// File: rtl/regfile_sb_busy.sv
// -----------------------------------------------------------------------------
// regfile_sb_busy
// DEPTH-bit busy scoreboard (one bit per register) with NUM_READ lookup ports.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   set_en_i / set_idx_i     mark a register busy at the next edge
//   clr_en_i / clr_idx_i     release a register (writeback) at the next edge
//   sweep_en_i / sweep_idx_i clear-sweep release of one register per edge
//   rd_idx_i                 lookup indices, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_busy_o                busy bit of each looked-up register
// The caller qualifies the enables (IDLE state, non-zero index).
// -----------------------------------------------------------------------------
module regfile_sb_busy
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int NUM_READ   = DEFAULT_NUM_READ
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           set_en_i,
  input  logic [ADDR_WIDTH-1:0]          set_idx_i,
  input  logic                           clr_en_i,
  input  logic [ADDR_WIDTH-1:0]          clr_idx_i,
  input  logic                           sweep_en_i,
  input  logic [ADDR_WIDTH-1:0]          sweep_idx_i,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_idx_i,
  output logic [NUM_READ-1:0]            rd_busy_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DEPTH-1:0] busy_q, busy_d;

  // Order matters: a set on the same edge as a release of the same register
  // wins, because the newly issued producer owns the register now.
  always_comb begin
    busy_d = busy_q;
    if (sweep_en_i) busy_d[sweep_idx_i] = 1'b0;
    if (clr_en_i)   busy_d[clr_idx_i]   = 1'b0;
    if (set_en_i)   busy_d[set_idx_i]   = 1'b1;
    busy_d[ADDR_WIDTH'(ZERO_REG)] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  // Bit 0 is held at zero, so a lookup of the zero register reads 0 naturally.
  for (genvar p = 0; p < NUM_READ; p++) begin : g_lookup
    logic [ADDR_WIDTH-1:0] idx;
    assign idx          = rd_idx_i[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign rd_busy_o[p] = busy_q[idx];
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// -----------------------------------------------------------------------------
// regfile_mp_sb
// Parametrised multi-read-port register file with a per-register busy
// scoreboard and a sequential clear sweep. Register 0 reads as zero and is
// never written or marked busy.
// Ports:
//   clock, ctrl_reset_n          clock (posedge), asynchronous active-low reset
//   ctrl_writeEn/_writeReg       write strobe and index; data_writeReg = data
//   ctrl_readReg                 read indices, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   data_readReg                 read data,    port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   busy_readReg                 busy bit of each read-port register
//   ctrl_busyEn/_busyReg         mark a register busy at the next edge
//   ctrl_clear                   start a clear sweep (sampled in IDLE)
//   clear_active                 high while the sweep runs; with two FSM states
//                                this is the complete state view
// Build option:
//   REGFILE_BYPASS_EN  a read hitting the register being written this cycle
//                      returns data_writeReg combinationally; otherwise reads
//                      return pre-edge contents.
// -----------------------------------------------------------------------------
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int NUM_READ   = DEFAULT_NUM_READ
) (
  input  logic                           clock,
  input  logic                           ctrl_reset_n,
  input  logic                           ctrl_writeEn,
  input  logic [ADDR_WIDTH-1:0]          ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0]          data_writeReg,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] ctrl_readReg,
  output logic [NUM_READ*DATA_WIDTH-1:0] data_readReg,
  output logic [NUM_READ-1:0]            busy_readReg,
  input  logic                           ctrl_busyEn,
  input  logic [ADDR_WIDTH-1:0]          ctrl_busyReg,
  input  logic                           ctrl_clear,
  output logic                           clear_active
);

  localparam int                    DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  in_idle;
  logic                  sweep_en;
  logic                  wr_fire;
  logic                  bsy_fire;
  logic [NUM_READ-1:0]   busy_lookup;

  assign in_idle      = (state_q == ST_IDLE);
  assign sweep_en     = (state_q == ST_CLEAR);
  assign clear_active = sweep_en;
  assign wr_fire      = ctrl_writeEn && (ctrl_writeReg != ZERO_IDX) && in_idle;
  assign bsy_fire     = ctrl_busyEn  && (ctrl_busyReg  != ZERO_IDX) && in_idle;

  // ---------------------------------------------------------------------------
  // Clear-sweep FSM. The counter walks 1..DEPTH-1, one register per edge, and
  // reloads 1 on the way back to IDLE so the next sweep starts ready.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_clear) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
          cnt_d   = FIRST_IDX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = FIRST_IDX;
      end
    endcase
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= FIRST_IDX;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Data array. Sweep and write are mutually exclusive (writes need IDLE).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (sweep_en) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_fire) begin
      mem_q[ctrl_writeReg] <= data_writeReg;
    end
  end

  // ---------------------------------------------------------------------------
  // Busy scoreboard: writeback releases, issue sets, sweep releases.
  // ---------------------------------------------------------------------------
  regfile_sb_busy #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_READ   (NUM_READ)
  ) u_busy (
    .clk_i       (clock),
    .rst_ni      (ctrl_reset_n),
    .set_en_i    (bsy_fire),
    .set_idx_i   (ctrl_busyReg),
    .clr_en_i    (wr_fire),
    .clr_idx_i   (ctrl_writeReg),
    .sweep_en_i  (sweep_en),
    .sweep_idx_i (cnt_q),
    .rd_idx_i    (ctrl_readReg),
    .rd_busy_o   (busy_lookup)
  );

  // ---------------------------------------------------------------------------
  // Read ports (combinational).
  // ---------------------------------------------------------------------------
  for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] idx;
    logic [DATA_WIDTH-1:0] arr_data;

    assign idx      = ctrl_readReg[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign arr_data = (idx == ZERO_IDX) ? '0 : mem_q[idx];

`ifdef REGFILE_BYPASS_EN
    // wr_fire already excludes the zero register, so a hit is never on r0.
    // The bypassed register is being released this edge, so it reads not busy
    // unless the same edge issues a new producer to it.
    logic hit;
    assign hit = wr_fire && (idx == ctrl_writeReg);
    assign data_readReg[p*DATA_WIDTH +: DATA_WIDTH] = hit ? data_writeReg : arr_data;
    assign busy_readReg[p] = hit ? (bsy_fire && (ctrl_busyReg == idx)) : busy_lookup[p];
`else
    assign data_readReg[p*DATA_WIDTH +: DATA_WIDTH] = arr_data;
    assign busy_readReg[p] = busy_lookup[p];
`endif
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp_sb
// Directed bench for regfile_mp_sb built with DATA_WIDTH=64, NUM_READ=4.
// Drivers set inputs just after the rising edge and queue the expected
// {data_readReg, busy_readReg, clear_active}; a monitor compares on the
// falling edge whenever a check is pending.
// -----------------------------------------------------------------------------
module tb_regfile_mp_sb;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int NR = 4;
  localparam int EW = NR*DW + NR + 1;

  localparam logic [DW-1:0] DEAD = 64'h0000_0000_0000_DEAD;
  localparam logic [DW-1:0] ONES = {DW{1'b1}};
  localparam logic [DW-1:0] V5   = 64'h0000_0000_1234_5678;
  localparam logic [DW-1:0] VA5  = 64'h0000_0000_0000_00A5;
  localparam logic [DW-1:0] V20  = 64'h0000_0000_0000_2020;
  localparam logic [DW-1:0] BEEF = 64'h0000_0000_0000_BEEF;
  localparam logic [DW-1:0] P1   = 64'h0123_4567_89AB_CDEF;
  localparam logic [DW-1:0] P2   = 64'hFEDC_BA98_7654_3210;

  // ---------------- clock / reset ----------------
  logic clock;
  logic ctrl_reset_n;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- DUT ----------------
  logic                 ctrl_writeEn;
  logic [AW-1:0]        ctrl_writeReg;
  logic [DW-1:0]        data_writeReg;
  logic [NR*AW-1:0]     ctrl_readReg;
  logic [NR*DW-1:0]     data_readReg;
  logic [NR-1:0]        busy_readReg;
  logic                 ctrl_busyEn;
  logic [AW-1:0]        ctrl_busyReg;
  logic                 ctrl_clear;
  logic                 clear_active;

  regfile_mp_sb #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_READ   (NR)
  ) dut (
    .clock         (clock),
    .ctrl_reset_n  (ctrl_reset_n),
    .ctrl_writeEn  (ctrl_writeEn),
    .ctrl_writeReg (ctrl_writeReg),
    .data_writeReg (data_writeReg),
    .ctrl_readReg  (ctrl_readReg),
    .data_readReg  (data_readReg),
    .busy_readReg  (busy_readReg),
    .ctrl_busyEn   (ctrl_busyEn),
    .ctrl_busyReg  (ctrl_busyReg),
    .ctrl_clear    (ctrl_clear),
    .clear_active  (clear_active)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  logic          chk_v;
  int            checks;
  int            failures;
  logic [EW-1:0] e_m;
  string         n_m;

  always @(negedge clock) begin
    if (chk_v) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_empty: got no expected entry, required one");
      end else begin
        e_m = exp_q.pop_front();
        n_m = name_q.pop_front();
        if ({data_readReg, busy_readReg, clear_active} !== e_m) begin
          failures++;
          $display("FAIL %s: got %h required %h", n_m,
                   {data_readReg, busy_readReg, clear_active}, e_m);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- driver helpers ----------------
  function automatic logic [EW-1:0] mk(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                       input logic [DW-1:0] d2, input logic [DW-1:0] d3,
                                       input logic [NR-1:0] b, input logic c);
    return {d3, d2, d1, d0, b, c};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [AW-1:0] a2, input logic [AW-1:0] a3);
    ctrl_readReg = {a3, a2, a1, a0};
  endtask

  task automatic idle_in();
    ctrl_writeEn = 1'b0;
    ctrl_busyEn  = 1'b0;
    ctrl_clear   = 1'b0;
  endtask

  task automatic check(input string nm, input logic [EW-1:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    chk_v = 1'b1;
    @(negedge clock);
    #1;
    chk_v = 1'b0;
  endtask

  task automatic write_one(input int r, input logic [DW-1:0] v);
    step();
    idle_in();
    ctrl_writeEn  = 1'b1;
    ctrl_writeReg = AW'(r);
    data_writeReg = v;
  endtask

  task automatic write_range(input int lo, input int hi, input logic [DW-1:0] v);
    for (int i = lo; i <= hi; i++) write_one(i, v);
    step();
    ctrl_writeEn = 1'b0;
  endtask

  // Reads every register in groups of four; r0 must read 0, others v.
  task automatic check_all(input string nm, input logic [DW-1:0] v);
    logic [DW-1:0] d [NR];
    for (int k = 0; k < 8; k++) begin
      for (int p = 0; p < NR; p++) d[p] = ((4*k + p) == 0) ? '0 : v;
      set_rd(AW'(4*k), AW'(4*k+1), AW'(4*k+2), AW'(4*k+3));
      check(nm, mk(d[0], d[1], d[2], d[3], 4'b0000, 1'b0));
      step();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks = 0; failures = 0; chk_v = 1'b0;
    ctrl_reset_n = 1'b1;
    idle_in();
    ctrl_writeReg = '0; data_writeReg = '0; ctrl_busyReg = '0;
    set_rd(0, 1, 2, 3);
    #2 ctrl_reset_n = 1'b0;

    step();
    check("reset", mk('0, '0, '0, '0, 4'b0000, 1'b0));
    ctrl_reset_n = 1'b1;

    // ---- write bypass ----
    step();
    ctrl_writeEn = 1'b1; ctrl_writeReg = 5'd5; data_writeReg = V5;
    set_rd(5, 5, 0, 6);
`ifdef REGFILE_BYPASS_EN
    check("bypass_same_cycle", mk(V5, V5, '0, '0, 4'b0000, 1'b0));
`else
    check("bypass_same_cycle", mk('0, '0, '0, '0, 4'b0000, 1'b0));
`endif
    step();
    idle_in();
    check("write_next_cycle", mk(V5, V5, '0, '0, 4'b0000, 1'b0));

    step();
    ctrl_writeEn = 1'b1; ctrl_writeReg = 5'd0; data_writeReg = ONES;
    set_rd(0, 5, 0, 0);
    check("write_r0_cycle", mk('0, V5, '0, '0, 4'b0000, 1'b0));
    step();
    idle_in();
    check("write_r0_after", mk('0, V5, '0, '0, 4'b0000, 1'b0));

    // ---- busy scoreboard ----
    step();
    ctrl_busyEn = 1'b1; ctrl_busyReg = 5'd7;
    set_rd(7, 5, 7, 0);
    check("busy_set_cycle", mk('0, V5, '0, '0, 4'b0000, 1'b0));
    step();
    idle_in();
    check("busy_set", mk('0, V5, '0, '0, 4'b0101, 1'b0));

    step();
    ctrl_writeEn = 1'b1; ctrl_writeReg = 5'd7; data_writeReg = VA5;
`ifdef REGFILE_BYPASS_EN
    check("busy_release_cycle", mk(VA5, V5, VA5, '0, 4'b0000, 1'b0));
`else
    check("busy_release_cycle", mk('0, V5, '0, '0, 4'b0101, 1'b0));
`endif
    step();
    idle_in();
    check("busy_released", mk(VA5, V5, VA5, '0, 4'b0000, 1'b0));

    step();
    ctrl_busyEn = 1'b1; ctrl_busyReg = 5'd7;
    ctrl_writeEn = 1'b1; ctrl_writeReg = 5'd7; data_writeReg = VA5;
`ifdef REGFILE_BYPASS_EN
    check("set_and_write_cycle", mk(VA5, V5, VA5, '0, 4'b0101, 1'b0));
`else
    check("set_and_write_cycle", mk(VA5, V5, VA5, '0, 4'b0000, 1'b0));
`endif
    step();
    idle_in();
    check("set_and_write_after", mk(VA5, V5, VA5, '0, 4'b0101, 1'b0));

    step();
    ctrl_busyEn = 1'b1; ctrl_busyReg = 5'd0;
    set_rd(0, 7, 0, 5);
    check("busy_r0_cycle", mk('0, VA5, '0, V5, 4'b0010, 1'b0));
    step();
    idle_in();
    check("busy_r0_ignored", mk('0, VA5, '0, V5, 4'b0010, 1'b0));

    // ---- fill every register, r0 stays zero, r7 busy released ----
    write_range(0, 31, DEAD);
    check_all("fill_dead", DEAD);

    // ---- clear sweep ----
    write_range(1, 31, ONES);
    ctrl_busyEn = 1'b1; ctrl_busyReg = 5'd9;
    step();
    idle_in();
    ctrl_clear = 1'b1;
    set_rd(3, 9, 31, 1);
    check("sweep_pre", mk(ONES, ONES, ONES, ONES, 4'b0010, 1'b0));
    for (int c = 1; c <= 31; c++) begin
      step();
      // writes, busy sets and a clear request are all ignored mid-sweep
      ctrl_clear    = (c == 15);
      ctrl_writeEn  = 1'b1; ctrl_writeReg = 5'd3; data_writeReg = 64'h1;
      ctrl_busyEn   = 1'b1; ctrl_busyReg  = 5'd3;
      check("sweep_run", mk((c > 3) ? '0 : ONES, (c > 9) ? '0 : ONES, ONES,
                            (c > 1) ? '0 : ONES, {1'b0, 1'b0, (c <= 9), 1'b0}, 1'b1));
    end
    step();
    idle_in();
    check_all("sweep_done", '0);

    // ---- reset in the middle of a sweep ----
    write_one(1, 64'h11);
    write_one(2, 64'h22);
    write_one(20, V20);
    step();
    idle_in();
    ctrl_busyEn = 1'b1; ctrl_busyReg = 5'd20;
    step();
    idle_in();
    ctrl_clear = 1'b1;
    set_rd(1, 2, 20, 0);
    for (int c = 1; c <= 10; c++) begin
      step();
      ctrl_clear = 1'b0;
    end
    check("sweep_at_10", mk('0, '0, V20, '0, 4'b0100, 1'b1));
    ctrl_reset_n = 1'b0;
    check("reset_mid_sweep", mk('0, '0, '0, '0, 4'b0000, 1'b0));
    ctrl_reset_n = 1'b1;
    write_one(2, BEEF);
    step();
    idle_in();
    set_rd(2, 20, 1, 0);
    check("write_after_reset", mk(BEEF, '0, '0, '0, 4'b0000, 1'b0));

    // ---- full sweep length after a mid-sweep reset ----
    ctrl_clear = 1'b1;
    set_rd(2, 0, 0, 0);
    for (int c = 1; c <= 31; c++) begin
      step();
      ctrl_clear = 1'b0;
      check("sweep_len", mk((c > 2) ? '0 : BEEF, '0, '0, '0, 4'b0000, 1'b1));
    end
    step();
    check("sweep_len_end", mk('0, '0, '0, '0, 4'b0000, 1'b0));

    // ---- wide data, repeated and zero ports ----
    write_one(1, P1);
    write_one(2, P2);
    step();
    idle_in();
    set_rd(1, 1, 2, 0);
    check("wide_multi_port", mk(P1, P1, P2, '0, 4'b0000, 1'b0));

    step();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d pending required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
